mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 64-bit instruction/data memory port between the instruction fetcher and the load/store unit.
- Grants one requester per issue slot and drives the memory request.
- Routes the fixed-latency read data back to the owner, with a valid pulse.
- Sits between the IFetcher/LSU and the memory model (fixed latency, registered read).

Parameters:
- MEM_LAT, 1, memory read latency in cycles (≥1); mem_rdata_i is valid MEM_LAT cycles after the issue cycle.
- STARVE_MAX, 4, consecutive fetch denials before fetch is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- if_req_i  in  1  fetch request.
- if_addr_i  in  25  fetch halfword address (PC).
- if_flush_i  in  1  discard any in-flight fetch return (branch/redirect).
- if_gnt_o  out  1  fetch granted this cycle.
- if_valid_o  out  1  fetch data valid.
- if_rdata_o  out  64  fetch data (8 bytes, little-endian).
- ls_req_i  in  1  load/store request.
- ls_we_i  in  1  1 = store.
- ls_addr_i  in  26  byte address.
- ls_be_i  in  8  byte enables.
- ls_wdata_i  in  64  store data.
- ls_gnt_o  out  1  load/store granted this cycle.
- ls_valid_o  out  1  load data valid, or store acknowledge.
- ls_rdata_o  out  64  load data.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  26  memory byte address.
- mem_be_o  out  8  memory byte enables.
- mem_wdata_o  out  64  memory write data.
- mem_rdata_i  in  64  memory read data.

Behaviour:
- States: IDLE, BUSY. One transaction outstanding at most. Latency counter lat_cnt counts MEM_LAT-1 down to 0.
- Issue slot = state IDLE, or BUSY with lat_cnt==0. Grants are combinational in the issue slot; mem_* are driven in the same cycle.
- Arbitration in an issue slot:
  - ls wins if starve_cnt < STARVE_MAX.
  - fetch wins if ls_req_i is low, or if starve_cnt == STARVE_MAX.
  - Exactly one of if_gnt_o / ls_gnt_o is high per grant.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) when if_req_i is high and ls is granted.
  - Cleared on a fetch grant.
  - Held otherwise.
- Fetch grant drives: mem_addr_o = {if_addr_i,1'b0}, mem_we_o=0, mem_be_o=8'hFF, mem_wdata_o=0.
- LS grant: ls_* are passed through to mem_*.
- With no grant, mem_req_o=0 and the other mem_* outputs are 0.
- On grant: owner is latched, lat_cnt=MEM_LAT-1, state goes to BUSY. With no grant in a slot, state goes to IDLE.
- Return: in BUSY with lat_cnt==0, the owner's valid_o is 1 and rdata_o = mem_rdata_i (combinational pass-through). The non-owner's rdata_o is 0.
- Store: ls_valid_o pulses as the acknowledge; ls_rdata_o = 0.
- Back-to-back: with MEM_LAT=1, one grant per cycle is sustained.
- Flush:
  - if_flush_i in BUSY with owner=fetch sets a drop flag, so if_valid_o is suppressed for that return.
  - if_flush_i in the return cycle itself suppresses if_valid_o in that cycle.
  - A fetch granted in the same cycle as the flush is NOT dropped.
  - Flush has no effect on LS transactions.
- Request inputs must stay stable until granted; the block does not register requests.
- Reset (reset==0 at a clock edge):
  - state=IDLE, lat_cnt=0, starve_cnt=0, drop flag=0.
  - All outputs 0 during and after reset until the next grant.
  - Any in-flight return is discarded, with no valid pulse.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_EN.
- Defined: adds outputs perf_if_wait_o[31:0] and perf_ls_wait_o[31:0].
  - Each counts cycles in which its requester has req high and no grant.
  - Counters saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package v850_mem_pkg holds:
  - typedef arb_state_e {IDLE, BUSY};
  - typedef owner_e {OWN_IF, OWN_LS};
  - constants MEM_DATA_W=64, MEM_ADDR_W=26, PC_W=25.
- Optional sub-module mem_arb_prio: combinational priority/starvation decision (inputs: requests, starve_cnt; outputs: grant vector).

Test Plan:
- Reset: hold reset=0 for 3 cycles with if_req_i=1 → all outputs 0. After release, if_gnt_o=1 in the first cycle and mem_addr_o=26'h0000004 for if_addr_i=25'h0000002.
- Fetch only, MEM_LAT=1: memory holds 64'h000B_1EC1_2141_125F at byte 0; request if_addr_i=0 → if_valid_o=1 the next cycle with that data. A continuous stream of if_addr_i=0,4,8 yields three consecutive valids.
- Contention: if_req_i and ls_req_i held high → LS granted 4 times, then fetch granted on the 5th slot, and starve_cnt returns to 0.
- Store: ls_we_i=1, ls_addr_i=26'h10, ls_be_i=8'h0F, ls_wdata_i=64'h1122_3344_5566_7788 → mem_* match in the grant cycle; ls_valid_o=1 next cycle with ls_rdata_o=0.
- Flush, MEM_LAT=3: grant fetch, pulse if_flush_i 1 cycle later → no if_valid_o. A fetch granted in the return slot returns normally 3 cycles later.
- Mid-operation reset: reset=0 one cycle after an LS grant → ls_valid_o never asserts, and state is IDLE after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// v850_mem_pkg: shared types and widths for the instruction/data memory port arbiter.
package v850_mem_pkg;

    localparam int MEM_DATA_W = 64;
    localparam int MEM_ADDR_W = 26;
    localparam int PC_W       = 25;

    typedef enum logic {IDLE, BUSY} arb_state_e;

    typedef enum logic {OWN_IF, OWN_LS} owner_e;

    // The fetcher addresses halfwords; the memory port wants a byte address.
    function automatic logic [MEM_ADDR_W-1:0] pc_to_byte_addr(input logic [PC_W-1:0] pc);
        return {pc, 1'b0};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared port.
// master = requesters plus memory model, slave = the arbiter.
interface mem_port_arbiter_if;
    import v850_mem_pkg::*;

    logic                  if_req_i;
    logic [PC_W-1:0]       if_addr_i;
    logic                  if_flush_i;
    logic                  if_gnt_o;
    logic                  if_valid_o;
    logic [MEM_DATA_W-1:0] if_rdata_o;

    logic                  ls_req_i;
    logic                  ls_we_i;
    logic [MEM_ADDR_W-1:0] ls_addr_i;
    logic [7:0]            ls_be_i;
    logic [MEM_DATA_W-1:0] ls_wdata_i;
    logic                  ls_gnt_o;
    logic                  ls_valid_o;
    logic [MEM_DATA_W-1:0] ls_rdata_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [MEM_ADDR_W-1:0] mem_addr_o;
    logic [7:0]            mem_be_o;
    logic [MEM_DATA_W-1:0] mem_wdata_o;
    logic [MEM_DATA_W-1:0] mem_rdata_i;

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        output ls_req_i, ls_we_i, ls_addr_i, ls_be_i, ls_wdata_i,
        output mem_rdata_i,
        input  if_gnt_o, if_valid_o, if_rdata_o,
        input  ls_gnt_o, ls_valid_o, ls_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        input  ls_req_i, ls_we_i, ls_addr_i, ls_be_i, ls_wdata_i,
        input  mem_rdata_i,
        output if_gnt_o, if_valid_o, if_rdata_o,
        output ls_gnt_o, ls_valid_o, ls_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o
    );

endinterface

// File: rtl/mem_port_arbiter_prio.sv
// mem_arb_prio: picks the winner of an issue slot. Load/store normally wins;
// fetch wins when alone or once it has been denied STARVE_MAX times in a row.
module mem_arb_prio #(
    parameter int STARVE_MAX = 4,
    parameter int STARVE_W   = 3
) (
    input  logic                enable,
    input  logic                if_req,
    input  logic                ls_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    output logic [1:0]          gnt
);

    // gnt[0] = fetch, gnt[1] = load/store; at most one bit is set
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (ls_req && (!if_req || (starve_cnt < STARVE_W'(STARVE_MAX)))) begin
                gnt = 2'b10;
            end else if (if_req) begin
                gnt = 2'b01;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 64-bit memory port between fetch and load/store,
// one transaction outstanding, fixed read latency MEM_LAT.
// Optional build macro MEM_PORT_ARBITER_PERF_EN adds per-requester wait-cycle counters.
module mem_port_arbiter
    import v850_mem_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    mem_port_arbiter_if.slave      bus
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [31:0]            perf_if_wait_o,
    output logic [31:0]            perf_ls_wait_o
`endif
);

    localparam int LAT_W    = ($clog2(MEM_LAT) > 0) ? $clog2(MEM_LAT) : 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_e          state;
    arb_state_e          state_next;
    logic [LAT_W-1:0]    lat_cnt;
    owner_e              owner;
    logic                owner_we;
    logic                drop;
    logic [STARVE_W-1:0] starve_cnt;
    logic                issue_slot;
    logic                ret_slot;
    logic [1:0]          gnt;

    // Outputs are forced quiet while reset is held, so the slot logic is gated by reset too.
    assign issue_slot = (state == IDLE) || (lat_cnt == '0);
    assign ret_slot   = reset && (state == BUSY) && (lat_cnt == '0);

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX),
        .STARVE_W   (STARVE_W)
    ) u_prio (
        .enable     (reset && issue_slot),
        .if_req     (bus.if_req_i),
        .ls_req     (bus.ls_req_i),
        .starve_cnt (starve_cnt),
        .gnt        (gnt)
    );

    // Next state, grant-side memory request and owner-routed return data
    always_comb begin
        state_next      = state;
        bus.if_gnt_o    = 1'b0;
        bus.ls_gnt_o    = 1'b0;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_be_o    = '0;
        bus.mem_wdata_o = '0;
        bus.if_valid_o  = 1'b0;
        bus.if_rdata_o  = '0;
        bus.ls_valid_o  = 1'b0;
        bus.ls_rdata_o  = '0;

        if (issue_slot) begin
            state_next = (gnt != 2'b00) ? BUSY : IDLE;
        end

        if (gnt[0]) begin
            bus.if_gnt_o   = 1'b1;
            bus.mem_req_o  = 1'b1;
            bus.mem_addr_o = pc_to_byte_addr(bus.if_addr_i);
            bus.mem_be_o   = 8'hFF;
        end else if (gnt[1]) begin
            bus.ls_gnt_o    = 1'b1;
            bus.mem_req_o   = 1'b1;
            bus.mem_we_o    = bus.ls_we_i;
            bus.mem_addr_o  = bus.ls_addr_i;
            bus.mem_be_o    = bus.ls_be_i;
            bus.mem_wdata_o = bus.ls_wdata_i;
        end

        if (ret_slot) begin
            if (owner == OWN_IF) begin
                if (!drop && !bus.if_flush_i) begin
                    bus.if_valid_o = 1'b1;
                    bus.if_rdata_o = bus.mem_rdata_i;
                end
            end else begin
                bus.ls_valid_o = 1'b1;
                if (!owner_we) begin
                    bus.ls_rdata_o = bus.mem_rdata_i;
                end
            end
        end
    end

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outstanding-transaction bookkeeping: owner, latency countdown and fetch drop flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            lat_cnt  <= '0;
            owner    <= OWN_IF;
            owner_we <= 1'b0;
            drop     <= 1'b0;
        end else if (gnt != 2'b00) begin
            owner    <= gnt[1] ? OWN_LS : OWN_IF;
            owner_we <= gnt[1] && bus.ls_we_i;
            lat_cnt  <= LAT_W'(MEM_LAT - 1);
            drop     <= 1'b0;
        end else begin
            if (lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (issue_slot) begin
                drop <= 1'b0;
            end else if ((state == BUSY) && (owner == OWN_IF) && bus.if_flush_i) begin
                drop <= 1'b1;
            end
        end
    end

    // Count consecutive fetch denials while load/store keeps winning
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (gnt[0]) begin
            starve_cnt <= '0;
        end else if (gnt[1] && bus.if_req_i && (starve_cnt != STARVE_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

`ifdef MEM_PORT_ARBITER_PERF_EN
    // Saturating counts of cycles each requester spent waiting for a grant
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_if_wait_o <= '0;
            perf_ls_wait_o <= '0;
        end else begin
            if (bus.if_req_i && !gnt[0] && (perf_if_wait_o != 32'hFFFF_FFFF)) begin
                perf_if_wait_o <= perf_if_wait_o + 32'd1;
            end
            if (bus.ls_req_i && !gnt[1] && (perf_ls_wait_o != 32'hFFFF_FFFF)) begin
                perf_ls_wait_o <= perf_ls_wait_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for two arbiters, MEM_LAT=1 and MEM_LAT=3.
module tb_mem_port_arbiter;
    import v850_mem_pkg::*;

    typedef struct packed {
        logic        if_req;
        logic [24:0] if_addr;
        logic        if_flush;
        logic        ls_req;
        logic        ls_we;
        logic [25:0] ls_addr;
        logic [7:0]  ls_be;
        logic [63:0] ls_wdata;
    } req_t;

    typedef struct {
        bit          is_ls;
        logic [63:0] data;
    } exp_t;

    localparam logic [63:0] M0 = 64'h000B_1EC1_2141_125F;
    localparam logic [63:0] M1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] M2 = 64'hDEAD_BEEF_0BAD_F00D;
    localparam logic [63:0] M3 = 64'hCAFE_F00D_1234_5678;
    localparam logic [63:0] M4 = 64'h4444_5555_6666_7777;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int          total = 0;
    int          bad   = 0;
    req_t        drv1  = '0;
    req_t        drv3  = '0;
    exp_t        exp1[$];
    exp_t        exp3[$];
    logic [63:0] mem1 [8];
    logic [63:0] mem3 [8];
    logic [63:0] rd1;
    logic [63:0] p0, p1, p2;

    mem_port_arbiter_if bus1 ();
    mem_port_arbiter_if bus3 ();

    assign bus1.if_req_i   = drv1.if_req;
    assign bus1.if_addr_i  = drv1.if_addr;
    assign bus1.if_flush_i = drv1.if_flush;
    assign bus1.ls_req_i   = drv1.ls_req;
    assign bus1.ls_we_i    = drv1.ls_we;
    assign bus1.ls_addr_i  = drv1.ls_addr;
    assign bus1.ls_be_i    = drv1.ls_be;
    assign bus1.ls_wdata_i = drv1.ls_wdata;
    assign bus1.mem_rdata_i = rd1;

    assign bus3.if_req_i   = drv3.if_req;
    assign bus3.if_addr_i  = drv3.if_addr;
    assign bus3.if_flush_i = drv3.if_flush;
    assign bus3.ls_req_i   = drv3.ls_req;
    assign bus3.ls_we_i    = drv3.ls_we;
    assign bus3.ls_addr_i  = drv3.ls_addr;
    assign bus3.ls_be_i    = drv3.ls_be;
    assign bus3.ls_wdata_i = drv3.ls_wdata;
    assign bus3.mem_rdata_i = p2;

`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] perf1_if, perf1_ls, perf3_if, perf3_ls;
`endif

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus1)
`ifdef MEM_PORT_ARBITER_PERF_EN
        ,
        .perf_if_wait_o (perf1_if),
        .perf_ls_wait_o (perf1_ls)
`endif
    );

    mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus3)
`ifdef MEM_PORT_ARBITER_PERF_EN
        ,
        .perf_if_wait_o (perf3_if),
        .perf_ls_wait_o (perf3_ls)
`endif
    );

    always #5 clk = ~clk;

    // Memory models: byte-enabled writes, registered read with 1 or 3 cycles of latency
    always @(posedge clk) begin
        if (!reset) begin
            for (int w = 0; w < 8; w++) begin
                mem1[w] <= '0;
                mem3[w] <= '0;
            end
            mem1[0] <= M0; mem1[1] <= M1; mem1[2] <= M2; mem1[3] <= M3; mem1[4] <= M4;
            mem3[0] <= M0; mem3[1] <= M1; mem3[2] <= M2; mem3[3] <= M3; mem3[4] <= M4;
        end else begin
            if (bus1.mem_req_o && bus1.mem_we_o) begin
                for (int b = 0; b < 8; b++) begin
                    if (bus1.mem_be_o[b]) mem1[bus1.mem_addr_o[5:3]][8*b +: 8] <= bus1.mem_wdata_o[8*b +: 8];
                end
            end
            if (bus3.mem_req_o && bus3.mem_we_o) begin
                for (int b = 0; b < 8; b++) begin
                    if (bus3.mem_be_o[b]) mem3[bus3.mem_addr_o[5:3]][8*b +: 8] <= bus3.mem_wdata_o[8*b +: 8];
                end
            end
        end
        rd1 <= mem1[bus1.mem_addr_o[5:3]];
        p0  <= mem3[bus3.mem_addr_o[5:3]];
        p1  <= p0;
        p2  <= p1;
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Scoreboard pop for one DUT whenever it presents a return
    task automatic monitor_port(input int sel, input logic ifv, input logic [63:0] ifd,
                                input logic lsv, input logic [63:0] lsd);
        exp_t        e;
        logic [129:0] got;
        logic [129:0] want;
        if (ifv || lsv) begin
            if ((sel == 1) ? (exp1.size() == 0) : (exp3.size() == 0)) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_valid dut%0d: if_valid=%b ls_valid=%b, want no return", sel, ifv, lsv);
            end else begin
                e    = (sel == 1) ? exp1.pop_front() : exp3.pop_front();
                got  = {ifv, ifd, lsv, lsd};
                want = e.is_ls ? {1'b0, 64'h0, 1'b1, e.data} : {1'b1, e.data, 1'b0, 64'h0};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("[TB] FAIL return_dut%0d: got %h, want %h", sel, got, want);
                end
            end
        end
    endtask

    // Monitor samples both DUTs on the falling edge
    always @(negedge clk) begin
        monitor_port(1, bus1.if_valid_o, bus1.if_rdata_o, bus1.ls_valid_o, bus1.ls_rdata_o);
        monitor_port(3, bus3.if_valid_o, bus3.if_rdata_o, bus3.ls_valid_o, bus3.ls_rdata_o);
    end

    task automatic apply_stimulus(input int sel, input req_t r);
        if (sel == 1) drv1 = r;
        else          drv3 = r;
    endtask

    function automatic req_t fetch_req(input logic [24:0] a);
        req_t r = '0;
        r.if_req  = 1'b1;
        r.if_addr = a;
        return r;
    endfunction

    function automatic req_t load_req(input logic [25:0] a);
        req_t r = '0;
        r.ls_req  = 1'b1;
        r.ls_addr = a;
        r.ls_be   = 8'hFF;
        return r;
    endfunction

    function automatic req_t flush_req();
        req_t r = '0;
        r.if_flush = 1'b1;
        return r;
    endfunction

    // One issue slot: drive, check grants mid-cycle, record the expected return
    task automatic slot(input int sel, input req_t r, input logic [1:0] want_gnt,
                        input bit push, input bit is_ls, input logic [63:0] data, input string name);
        exp_t e;
        apply_stimulus(sel, r);
        @(negedge clk);
        if (sel == 1) begin
            check_output({name, "_gnt"}, {62'b0, bus1.ls_gnt_o, bus1.if_gnt_o}, {62'b0, want_gnt});
            if (want_gnt == 2'b00)
                check_output({name, "_idle_mem"}, {29'b0, bus1.mem_req_o, bus1.mem_we_o, bus1.mem_be_o, bus1.mem_addr_o}, 64'h0);
        end else begin
            check_output({name, "_gnt"}, {62'b0, bus3.ls_gnt_o, bus3.if_gnt_o}, {62'b0, want_gnt});
            if (want_gnt == 2'b00)
                check_output({name, "_idle_mem"}, {29'b0, bus3.mem_req_o, bus3.mem_we_o, bus3.mem_be_o, bus3.mem_addr_o}, 64'h0);
        end
        if (push) begin
            e.is_ls = is_ls;
            e.data  = data;
            if (sel == 1) exp1.push_back(e);
            else          exp3.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        req_t r;
        exp_t e;

        // Reset held with a fetch pending: everything stays quiet
        apply_stimulus(1, fetch_req(25'h0000002));
        apply_stimulus(3, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_outputs", {bus1.if_gnt_o, bus1.ls_gnt_o, bus1.mem_req_o, bus1.if_valid_o,
                                     bus1.ls_valid_o, bus1.mem_addr_o}, 64'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_output("rst_rel_gnt", bus1.if_gnt_o, 64'h1);
        check_output("rst_rel_addr", bus1.mem_addr_o, 64'h0000004);
        e.is_ls = 1'b0;
        e.data  = M0;
        exp1.push_back(e);
        @(posedge clk);
        #1;

        // Back-to-back fetch stream with MEM_LAT=1
        slot(1, fetch_req(25'h0), 2'b01, 1, 0, M0, "fetch0");
        slot(1, fetch_req(25'h4), 2'b01, 1, 0, M1, "fetch4");
        slot(1, fetch_req(25'h8), 2'b01, 1, 0, M2, "fetch8");
        slot(1, '0, 2'b00, 0, 0, 64'h0, "idle1");

        // Contention: four load wins, then fetch forced through
        r = fetch_req(25'h10);
        r.ls_req  = 1'b1;
        r.ls_addr = 26'h18;
        r.ls_be   = 8'hFF;
        for (int i = 0; i < 4; i++) slot(1, r, 2'b10, 1, 1, M3, "contend_ls");
        check_output("starve_sat", u_dut1.starve_cnt, 64'd4);
        slot(1, r, 2'b01, 1, 0, M4, "contend_if");
        check_output("starve_clear", u_dut1.starve_cnt, 64'd0);
        slot(1, '0, 2'b00, 0, 0, 64'h0, "idle2");

        // Store: pass-through to memory, acknowledge with zero data
        r = '0;
        r.ls_req   = 1'b1;
        r.ls_we    = 1'b1;
        r.ls_addr  = 26'h10;
        r.ls_be    = 8'h0F;
        r.ls_wdata = 64'h1122_3344_5566_7788;
        apply_stimulus(1, r);
        @(negedge clk);
        check_output("store_gnt", {bus1.ls_gnt_o, bus1.if_gnt_o, bus1.mem_req_o, bus1.mem_we_o}, 64'hB);
        check_output("store_addr", bus1.mem_addr_o, 64'h10);
        check_output("store_be", bus1.mem_be_o, 64'h0F);
        check_output("store_wdata", bus1.mem_wdata_o, 64'h1122_3344_5566_7788);
        e.is_ls = 1'b1;
        e.data  = 64'h0;
        exp1.push_back(e);
        @(posedge clk);
        #1;
        slot(1, load_req(26'h10), 2'b10, 1, 1, 64'hDEAD_BEEF_5566_7788, "load_after_store");
        slot(1, '0, 2'b00, 0, 0, 64'h0, "idle3");

        // Flush in the return cycle drops the fetch; loads ignore flush
        slot(1, fetch_req(25'h0), 2'b01, 0, 0, 64'h0, "fetch_flushed");
        slot(1, flush_req(), 2'b00, 0, 0, 64'h0, "flush_ret");
        r = load_req(26'h08);
        r.if_flush = 1'b1;
        slot(1, r, 2'b10, 1, 1, M1, "load_flush");
        slot(1, flush_req(), 2'b00, 0, 0, 64'h0, "flush_ls_ret");
        slot(1, '0, 2'b00, 0, 0, 64'h0, "idle4");

        // MEM_LAT=3: flush one cycle after grant, new fetch in the return slot survives
        slot(3, fetch_req(25'h0), 2'b01, 0, 0, 64'h0, "l3_fetch_drop");
        slot(3, flush_req(), 2'b00, 0, 0, 64'h0, "l3_flush");
        slot(3, '0, 2'b00, 0, 0, 64'h0, "l3_wait");
        slot(3, fetch_req(25'h8), 2'b01, 1, 0, M2, "l3_fetch_keep");
        for (int i = 0; i < 3; i++) slot(3, '0, 2'b00, 0, 0, 64'h0, "l3_drain");

        // MEM_LAT=3: no grant while a transaction is in flight
        slot(3, load_req(26'h08), 2'b10, 1, 1, M1, "l3_load");
        slot(3, fetch_req(25'h0), 2'b00, 0, 0, 64'h0, "l3_busy1");
        slot(3, fetch_req(25'h0), 2'b00, 0, 0, 64'h0, "l3_busy2");
        slot(3, fetch_req(25'h0), 2'b01, 1, 0, M0, "l3_fetch_next");
        for (int i = 0; i < 3; i++) slot(3, '0, 2'b00, 0, 0, 64'h0, "l3_drain2");

        // Reset one cycle after a load grant discards its return
        slot(3, load_req(26'h18), 2'b10, 0, 0, 64'h0, "l3_load_rst");
        reset = 1'b0;
        @(negedge clk);
        check_output("midrst_quiet", {bus3.ls_valid_o, bus3.if_valid_o, bus3.mem_req_o}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_output("midrst_state", u_dut3.state, IDLE);
        for (int i = 0; i < 4; i++) slot(3, '0, 2'b00, 0, 0, 64'h0, "l3_after_rst");

        repeat (4) @(posedge clk);
        #1;
        check_output("pending_dut1", exp1.size(), 64'd0);
        check_output("pending_dut3", exp3.size(), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
